rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Round-robin arbiter that shares one 4:1 multiplexer path between four requesters. It owns the mux select: it grants exactly one requester at a time, drives the encoded select, and routes that requester's data to the shared output. A hold limit stops one requester from monopolising the path. It sits directly in front of the shared downstream consumer, replacing free-running select lines with an arbitrated, registered select.

## Interface
- W, 1: data width of each requester input and of f
- MAX_HOLD, 8: maximum consecutive grant cycles while another request is pending (legal range 2..255)

- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  reset, synchronous and active-low
- req  in  4  request per requester; req[0]..req[3] map to inputs a..d
- a, b, c, d  in  W each  requester data
- gnt  out  4  one-hot grant, registered; all-zero when idle
- sel  out  2  encoded grant index, registered; 00=a, 01=b, 10=c, 11=d
- busy  out  1  registered; 1 while any grant is active
- f  out  W  selected data, combinational from sel; forced to 0 when busy=0

## Operation
- Internal state:
  - FSM state: IDLE or GRANT.
  - ptr[1:0]: round-robin priority start.
  - cnt[7:0]: hold counter.
- Round-robin search: scan ptr, ptr+1, ptr+2, ptr+3, each mod 4. The first index with req set wins.
- IDLE:
  - gnt=0 and busy=0. sel keeps its last value.
  - If req != 0, the winner w is registered: gnt=1<<w, sel=w, busy=1, cnt=0, ptr=w+1 mod 4, next state GRANT.
- GRANT, owner g:
  - Release: req[g]=0 sampled. If other requests are present, the RR winner is granted on the same edge with no idle bubble. Otherwise go to IDLE with gnt=0 and busy=0.
  - Forced rotation: req[g]=1, cnt=MAX_HOLD-1, and any other req bit is set. The RR winner among the other requesters is granted. ptr is already g+1, so g cannot win.
  - Otherwise g keeps the grant. cnt increments and saturates at MAX_HOLD-1. When no other request is pending, the owner keeps the grant indefinitely.
- Every new grant, including back-to-back handovers, loads cnt=0 and ptr=winner+1.
- Data path: f = a/b/c/d selected by sel when busy=1, otherwise f=0. The mux is purely combinational.
- Invariants, checked by assertion:
  - gnt is always one-hot or zero.
  - busy equals the OR of gnt.
  - sel matches the gnt index whenever busy=1.
- Reset (rst_n=0 at a clock edge), values apply from the same edge:
  - gnt=0, sel=00, busy=0, ptr=00, cnt=0, state IDLE, f=0.
  - Reset during GRANT drops the grant immediately. The first arbitration after reset starts from requester 0.
- Requests and data are sampled only at the clock edge. Glitches between edges are ignored.

## Timing
- Grant latency: 1 cycle. A req sampled at edge N appears on gnt/sel/busy after edge N.
- Release latency: 1 cycle. A req[g]=0 sampled at edge N means gnt[g]=0 after edge N.
- Handover: zero idle cycles between consecutive owners when requests overlap.
- Forced rotation: the owner holds for exactly MAX_HOLD cycles, then the grant moves on the next edge.
- f changes combinationally with data inputs and with sel/busy after each edge. There is no added latency on data.
- Simultaneous events:
  - A release and a new request on the same edge are handled by a single arbitration.
  - If rst_n=0, reset wins over all other events.

## Test plan
- Reset then single request: rst_n low 2 cycles, then req=0001 with a=1 -> after the next edge gnt=0001, sel=00, busy=1, f=1. Drop req -> gnt=0000, busy=0, f=0 one edge later.
- Fairness: req=1111 held and each requester releases after 1 cycle of grant -> grant order 0,1,2,3,0 with no idle cycles.
- Hold limit, MAX_HOLD=8: req[1] held, req[3] raised 2 cycles later and held -> gnt=0010 for exactly 8 cycles, then gnt=1000. With req[3] absent, gnt=0010 persists for more than 20 cycles.
- Pointer wrap: last grant to requester 3, then req=0011 -> requester 0 wins. Then with req=0011 still held, requester 1 wins next.
- Mid-grant reset: in GRANT on requester 2 with req=0100, pulse rst_n low 1 cycle -> gnt=0000, sel=00, busy=0 at that edge. After reset, req=0110 -> requester 1 is granted first.
- Data routing, W=4: a=1, b=2, c=4, d=8, each requester granted in turn -> f shows 1, 2, 4, 8 while granted and 0 in idle gaps. gnt stays one-hot or zero throughout.

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - request/data/grant bundle between requesters and the shared-path arbiter
interface rr_mux_arbiter_if #(
    parameter int W = 1
);
    logic [3:0]   req;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         busy;
    logic [W-1:0] f;

    modport master (
        output req, a, b, c, d,
        input  gnt, sel, busy, f
    );

    modport slave (
        input  req, a, b, c, d,
        output gnt, sel, busy, f
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter with hold limit owning a registered 4:1 mux select
module rr_mux_arbiter #(
    parameter int W        = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_mux_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] cnt;

    logic [3:0] cand;
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    logic       hold_max;
    logic       owner_req;
    logic       do_grant;
    logic       do_release;

    // The current owner is masked out, so forced rotation and release share one search.
    always_comb begin
        cand  = bus.req & ~bus.gnt;
        win   = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (cand[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        hold_max   = (cnt == 8'(MAX_HOLD - 1));
        owner_req  = bus.req[bus.sel];
        do_grant   = found && ((state == IDLE) || !owner_req || hold_max);
        do_release = (state == GRANT) && !owner_req && !found;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            cnt      <= 8'd0;
            bus.gnt  <= 4'd0;
            bus.sel  <= 2'd0;
            bus.busy <= 1'b0;
        end else if (do_grant) begin
            state    <= GRANT;
            ptr      <= win + 2'd1;
            cnt      <= 8'd0;
            bus.gnt  <= 4'd1 << win;
            bus.sel  <= win;
            bus.busy <= 1'b1;
        end else if (do_release) begin
            state    <= IDLE;
            bus.gnt  <= 4'd0;
            bus.busy <= 1'b0;
        end else if (state == GRANT && !hold_max) begin
            cnt <= cnt + 8'd1;
        end
    end

    always_comb begin
        bus.f = '0;
        if (bus.busy) begin
            case (bus.sel)
                2'd0:    bus.f = bus.a;
                2'd1:    bus.f = bus.b;
                2'd2:    bus.f = bus.c;
                default: bus.f = bus.d;
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) $onehot0(bus.gnt));
    a_busy_or:    assert property (@(posedge clk) bus.busy == (|bus.gnt));
    a_sel_match:  assert property (@(posedge clk) bus.busy |-> bus.gnt[bus.sel]);
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter
module tb_rr_mux_arbiter;
    localparam int W        = 4;
    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.W(W)) bus ();

    rr_mux_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]   gnt;
        logic [1:0]   sel;
        logic         busy;
        logic [W-1:0] f;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    int         m_owner = -1;
    int         m_ptr   = 0;
    int         m_hold  = 0;
    logic [1:0] m_sel   = 2'd0;

    function automatic int pick(input logic [3:0] m, input int start);
        for (int i = 0; i < 4; i++)
            if (m[(start + i) % 4]) return (start + i) % 4;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic take(input int w);
        m_owner = w;
        m_sel   = 2'(w);
        m_ptr   = (w + 1) % 4;
        m_hold  = 0;
    endtask

    // One cycle of stimulus; the reference model decides what the next edge must produce.
    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [W-1:0] da, input logic [W-1:0] db,
                        input logic [W-1:0] dc, input logic [W-1:0] dd);
        logic [3:0]   others;
        logic [W-1:0] data [4];
        exp_t         e;
        @(negedge clk);
        rst_n = r;
        bus.req = rq;
        bus.a = da; bus.b = db; bus.c = dc; bus.d = dd;
        data[0] = da; data[1] = db; data[2] = dc; data[3] = dd;
        if (!r) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 2'd0;
        end else if (m_owner < 0) begin
            if (rq != 4'd0) take(pick(rq, m_ptr));
        end else begin
            others = rq & ~(4'd1 << m_owner);
            if (!rq[m_owner]) begin
                if (others != 4'd0) take(pick(others, m_ptr));
                else m_owner = -1;
            end else if (m_hold == MAX_HOLD - 1 && others != 4'd0) begin
                take(pick(others, m_ptr));
            end else if (m_hold < MAX_HOLD - 1) begin
                m_hold++;
            end
        end
        e.gnt  = (m_owner >= 0) ? (4'd1 << m_owner) : 4'd0;
        e.sel  = m_sel;
        e.busy = (m_owner >= 0);
        e.f    = (m_owner >= 0) ? data[m_owner] : '0;
        expq.push_back(e);
    endtask

    task automatic rq_n(input logic [3:0] rq, input int n);
        for (int i = 0; i < n; i++) step(1'b1, rq, 4'h1, 4'h2, 4'h4, 4'h8);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("gnt",  32'(bus.gnt),  32'(e.gnt));
                check("sel",  32'(bus.sel),  32'(e.sel));
                check("busy", 32'(bus.busy), 32'(e.busy));
                check("f",    32'(bus.f),    32'(e.f));
            end
        end
    end

    initial begin : driver
        logic [3:0] rq;
        bus.req = 4'd0;
        bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;

        step(1'b0, 4'd0, 4'h1, 4'h2, 4'h4, 4'h8);
        step(1'b0, 4'd0, 4'h1, 4'h2, 4'h4, 4'h8);
        rq_n(4'b0001, 3);
        rq_n(4'b0000, 2);

        for (int i = 0; i < 10; i++) begin
            rq = 4'b1111;
            if (m_owner >= 0) rq[m_owner] = 1'b0;
            rq_n(rq, 1);
        end
        rq_n(4'b0000, 2);

        rq_n(4'b0010, 2);
        rq_n(4'b1010, 12);
        rq_n(4'b0000, 2);
        rq_n(4'b0010, 25);
        rq_n(4'b0000, 1);

        rq_n(4'b1000, 2);
        rq_n(4'b0011, 12);
        rq_n(4'b0000, 1);

        rq_n(4'b0100, 3);
        step(1'b0, 4'b0100, 4'h1, 4'h2, 4'h4, 4'h8);
        rq_n(4'b0110, 3);
        rq_n(4'b0000, 1);

        for (int k = 0; k < 4; k++) begin
            rq_n(4'd1 << k, 2);
            rq_n(4'b0000, 1);
        end

        rq = 4'd0;
        for (int i = 0; i < 2000; i++) begin
            for (int j = 0; j < 4; j++)
                if ($urandom_range(7) == 0) rq[j] = ~rq[j];
            step(($urandom_range(199) != 0), rq,
                 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
